// File: rtl/mips8_pkg.sv
// Shared definitions for the mips8 core: fetch FSM states, opcodes consumed by
// the control unit, and the default address width.
package mips8_pkg;

    localparam int ADDR_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } fetch_state_e;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_LB    = 6'h20,
        OP_SB    = 6'h28
    } opcode_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: assembles a 32-bit little-endian instruction from four
// byte reads of an 8-bit memory, then advances the PC by 4.
module instr_fetch
    import mips8_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_target,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic              instr_valid,
    output logic              busy,
    output logic [ADDR_W-1:0] pc,
    output fetch_state_e      dbg_state
);

    fetch_state_e      state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] fetch_base_q, fetch_base_d;
    logic [31:0]       shadow_q, shadow_d;
    logic [31:0]       instr_q, instr_d;
    logic              instr_valid_q, instr_valid_d;

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        pc_d          = pc_q;
        fetch_base_d  = fetch_base_q;
        shadow_d      = shadow_q;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pc_load) pc_d = pc_target;
                if (start) begin
                    state_d      = ST_FETCH;
                    byte_cnt_d   = 2'd0;
                    fetch_base_d = pc_load ? pc_target : pc_q;
                end
            end
            ST_FETCH: begin
                if (mem_ready) begin
                    shadow_d[{byte_cnt_q, 3'b000} +: 8] = mem_rdata;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    // Final byte goes straight into instr so no partial value is ever visible.
                    if (byte_cnt_q == 2'd3) begin
                        state_d       = ST_DONE;
                        instr_d       = shadow_d;
                        instr_valid_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                pc_d    = fetch_base_q + ADDR_W'(4);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            byte_cnt_q    <= 2'd0;
            pc_q          <= PC_RESET;
            fetch_base_q  <= PC_RESET;
            shadow_q      <= 32'd0;
            instr_q       <= 32'd0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            pc_q          <= pc_d;
            fetch_base_q  <= fetch_base_d;
            shadow_q      <= shadow_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign mem_rd      = (state_q == ST_FETCH);
    assign mem_addr    = mem_rd ? fetch_base_q + ADDR_W'(byte_cnt_q) : pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign instr_valid = instr_valid_q;
    assign busy        = (state_q != ST_IDLE);
    assign pc          = pc_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized fetch sequences against a byte-array memory model.
module tb_instr_fetch;
    import mips8_pkg::*;

    logic         clk;
    logic         reset;
    logic         start;
    logic         pc_load;
    logic [7:0]   pc_target;
    logic         mem_rd;
    logic [7:0]   mem_addr;
    logic [7:0]   mem_rdata;
    logic         mem_ready;
    logic [31:0]  instr;
    logic [5:0]   opcode;
    logic         instr_valid;
    logic         busy;
    logic [7:0]   pc;
    fetch_state_e dbg_state;

    logic [7:0]   mem_arr [256];
    logic [31:0]  exp_q[$];
    logic [7:0]   exp_pc;
    logic [31:0]  last_instr;
    int           total;
    int           bad;

    instr_fetch #(.ADDR_W(8), .PC_RESET(8'h00)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .instr      (instr),
        .opcode     (opcode),
        .instr_valid(instr_valid),
        .busy       (busy),
        .pc         (pc),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem_arr[mem_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One complete fetch; the expected word is assembled straight from the memory array.
    task automatic do_fetch(input bit load, input logic [7:0] tgt, input int wait_byte,
                            input int wait_n, input int rand_pct, input bit noise);
        logic [7:0]  base;
        logic [7:0]  a;
        logic [31:0] exp_word;
        logic        rdy;
        int          k;
        int          waited;
        int          dir_waited;
        int          cycles;
        base = load ? tgt : exp_pc;
        if (load) exp_pc = tgt;
        for (int i = 0; i < 4; i++) begin
            a = base + 8'(i);
            exp_word[8*i +: 8] = mem_arr[a];
        end
        exp_q.push_back(exp_word);
        start = 1'b1; pc_load = load; pc_target = tgt;
        @(posedge clk); @(negedge clk);
        start = 1'b0; pc_load = 1'b0;
        k = 0; waited = 0; dir_waited = 0; cycles = 0;
        while (k < 4 && cycles < 40) begin
            check("fetch_busy", 32'(busy), 32'd1);
            check("fetch_mem_rd", 32'(mem_rd), 32'd1);
            check("fetch_addr", 32'(mem_addr), 32'(8'(base + 8'(k))));
            check("fetch_instr_hold", instr, last_instr);
            check("fetch_no_valid", 32'(instr_valid), 32'd0);
            check("fetch_state", 32'(dbg_state), 32'(ST_FETCH));
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                pc_load = 1'($urandom_range(0, 1));
                pc_target = 8'($urandom);
            end
            rdy = 1'b1;
            if (k == wait_byte && dir_waited < wait_n) begin
                rdy = 1'b0; dir_waited++; waited++;
            end else if (int'($urandom_range(0, 99)) < rand_pct && waited < 6) begin
                rdy = 1'b0; waited++;
            end
            mem_ready = rdy;
            @(posedge clk); @(negedge clk);
            if (rdy) k++;
            cycles++;
        end
        check("fetch_bytes", 32'(k), 32'd4);
        check("fetch_latency", 32'(cycles), 32'(4 + waited));
        mem_ready = 1'b0;
        if (noise) begin
            start = 1'b1; pc_load = 1'b1; pc_target = 8'($urandom);
        end else begin
            start = 1'b0; pc_load = 1'b0;
        end
        exp_word = exp_q.pop_front();
        check("done_valid", 32'(instr_valid), 32'd1);
        check("done_instr", instr, exp_word);
        check("done_opcode", 32'(opcode), 32'(exp_word[31:26]));
        check("done_busy", 32'(busy), 32'd1);
        check("done_mem_rd", 32'(mem_rd), 32'd0);
        check("done_addr", 32'(mem_addr), 32'(exp_pc));
        check("done_state", 32'(dbg_state), 32'(ST_DONE));
        @(posedge clk); @(negedge clk);
        start = 1'b0; pc_load = 1'b0;
        exp_pc = base + 8'd4;
        last_instr = exp_word;
        check("idle_valid", 32'(instr_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_pc", 32'(pc), 32'(exp_pc));
        check("idle_addr", 32'(mem_addr), 32'(exp_pc));
        check("idle_instr", instr, last_instr);
        check("idle_state", 32'(dbg_state), 32'(ST_IDLE));
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b0; start = 1'b0; pc_load = 1'b0; pc_target = 8'h00; mem_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem_arr[i] = 8'($urandom);
        mem_arr[0] = 8'h20; mem_arr[1] = 8'h00; mem_arr[2] = 8'h00; mem_arr[3] = 8'hA0;
        exp_pc = 8'h00; last_instr = 32'd0;

        // reset values
        @(negedge clk);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'h00);
        check("rst_opcode", 32'(opcode), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", 32'(pc), 32'h00);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // SB instruction at address 0, no wait states
        do_fetch(1'b0, 8'h00, -1, 0, 0, 1'b0);
        check("sb_instr", instr, 32'hA000_0020);
        check("sb_opcode", 32'(opcode), 32'(OP_SB));
        check("sb_pc", 32'(pc), 32'h04);

        // same words again with two wait states on byte 1
        do_fetch(1'b1, 8'h00, 1, 2, 0, 1'b0);

        // load and start together
        do_fetch(1'b1, 8'h40, -1, 0, 0, 1'b0);
        check("load_pc", 32'(pc), 32'h44);

        // pc_load alone in IDLE, then wrap-around fetch
        pc_load = 1'b1; pc_target = 8'hFE;
        @(posedge clk); @(negedge clk);
        pc_load = 1'b0;
        check("load_only_pc", 32'(pc), 32'hFE);
        check("load_only_busy", 32'(busy), 32'd0);
        exp_pc = 8'hFE;
        do_fetch(1'b0, 8'h00, -1, 0, 0, 1'b0);
        check("wrap_pc", 32'(pc), 32'h02);

        // start/pc_load noise during FETCH and DONE
        do_fetch(1'b0, 8'h00, 2, 1, 20, 1'b1);

        // asynchronous reset during byte 2
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0; mem_ready = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        mem_ready = 1'b0;
        check("mid_addr", 32'(mem_addr), 32'(8'(exp_pc + 8'd2)));
        #2 reset = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_mem_rd", 32'(mem_rd), 32'd0);
        check("arst_instr", instr, 32'd0);
        check("arst_pc", 32'(pc), 32'h00);
        check("arst_addr", 32'(mem_addr), 32'h00);
        check("arst_opcode", 32'(opcode), 32'd0);
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1;
            @(negedge clk);
            check("arst_no_valid", 32'(instr_valid), 32'd0);
        end
        reset = 1'b1; mem_ready = 1'b0;
        exp_pc = 8'h00; last_instr = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_valid", 32'(instr_valid), 32'd0);
            check("post_rst_busy", 32'(busy), 32'd0);
        end

        // randomized fetches
        for (int n = 0; n < 20; n++) begin
            do_fetch(1'($urandom_range(0, 1)), 8'($urandom), -1, 0, 30, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: ADDR_W, 8, width of the byte address and the program counter.
REQ-002 Parameter: PC_RESET, 8'h00, program counter value after reset.
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 Port: start  input  1  request to fetch the next instruction; sampled only in IDLE.
REQ-006 Port: pc_load  input  1  load pc_target into the PC (branch/jump); sampled only in IDLE.
REQ-007 Port: pc_target  input  ADDR_W  new PC value for pc_load.
REQ-008 Port: mem_rd  output  1  byte read request to the 8-bit memory.
REQ-009 Port: mem_addr  output  ADDR_W  byte address of the current read.
REQ-010 Port: mem_rdata  input  8  read data, valid when mem_ready=1.
REQ-011 Port: mem_ready  input  1  memory completes the current byte read this cycle.
REQ-012 Port: instr  output  32  last completely fetched instruction.
REQ-013 Port: opcode  output  6  instr[31:26], consumed by the control unit.
REQ-014 Port: instr_valid  output  1  one-cycle pulse: instr/opcode were just updated.
REQ-015 Port: busy  output  1  high whenever state is not IDLE.
REQ-016 Port: pc  output  ADDR_W  current program counter.

Function
REQ-017 The FSM SHALL have three states: IDLE, FETCH, DONE.
REQ-018 In IDLE, start=1 SHALL cause a transition to FETCH with byte_cnt=0 and fetch_base=pc, or fetch_base=pc_target if pc_load=1 in the same cycle.
REQ-019 In IDLE, pc_load=1 SHALL set pc to pc_target, with or without start.
REQ-020 In FETCH, mem_rd SHALL be 1 and mem_addr SHALL be fetch_base+byte_cnt, combinationally and modulo 2^ADDR_W.
REQ-021 In FETCH, each cycle with mem_ready=1 SHALL write mem_rdata into shadow bits [8k+7:8k], k=byte_cnt (little-endian), then increment byte_cnt.
REQ-022 In FETCH, a cycle with mem_ready=0 SHALL hold byte_cnt, the shadow register and mem_addr (wait states, unbounded).
REQ-023 In FETCH, mem_ready=1 with byte_cnt=3 SHALL cause a transition to DONE.
REQ-024 In DONE, instr SHALL be loaded from the shadow register with the final byte merged, and instr_valid=1 for exactly this one cycle.
REQ-025 In DONE, pc SHALL be set to fetch_base+4 modulo 2^ADDR_W (0xFE+4 -> 0x02), then the FSM SHALL return to IDLE.
REQ-026 instr SHALL remain unchanged during FETCH; there are no partial updates.
REQ-027 start and pc_load SHALL be ignored in FETCH and DONE.
REQ-028 With mem_ready held at 1, start sampled at edge t SHALL give FETCH in cycles t+1..t+4 and instr_valid in cycle t+5 (5-cycle latency).
REQ-029 In IDLE and DONE, mem_rd SHALL be 0 and mem_addr SHALL equal pc.
REQ-030 opcode SHALL always equal instr[31:26].

Reset
REQ-031 While reset=0, the block SHALL asynchronously force state=IDLE, byte_cnt=0, pc=PC_RESET, fetch_base=PC_RESET, shadow=0 and instr=0.
REQ-032 Under reset, outputs SHALL read instr_valid=0, busy=0, mem_rd=0, mem_addr=PC_RESET and opcode=0.
REQ-033 Reset asserted mid-FETCH SHALL abandon the fetch, leave instr at 0 and produce no instr_valid pulse.
REQ-034 Reset release SHALL be synchronised by the system; the block takes its first transition on the first rising edge after reset=1.

Structure
REQ-035 The shared package mips8_pkg SHALL hold the fetch state enum, the opcode enum (LB, SB, BEQ, J, RTYPE) shared with the control unit, and ADDR_W default.
REQ-036 The block SHALL be a single module with no sub-module; the PC, byte counter and shadow register are inline.

Verification
REQ-037 pc=0x00, memory[0..3]=20 00 00 A0, mem_ready=1, start pulse -> mem_addr 0,1,2,3; instr=0xA0000020, opcode=0x28 (SB), instr_valid one cycle at t+5, pc=0x04.
REQ-038 Same fetch with mem_ready=0 for 2 cycles on byte 1 -> mem_addr holds 0x01 for 3 cycles; instr_valid at t+7; instr unchanged until then.
REQ-039 IDLE, pc_load=1, pc_target=0x40, start=1 same cycle -> reads 0x40..0x43; pc=0x44 after DONE.
REQ-040 pc=0xFE, start -> mem_addr 0xFE,0xFF,0x00,0x01; pc=0x02 after DONE.
REQ-041 reset=0 during byte 2 of a fetch -> busy=0, mem_rd=0, instr=0, pc=PC_RESET immediately (asynchronous); no instr_valid pulse.
REQ-042 start and pc_load pulsed during FETCH -> ignored; pc advances by exactly 4 and a single instr_valid pulse occurs.
